// File: rtl/param_sequence_detector.sv
// Programmable PAT_W-bit serial pattern detector with overlap control and a saturating match counter.
// Optional combinational early-match output is enabled by defining PARAM_SEQ_DET_MEALY_EN.
module param_sequence_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap_en,
  input  logic             x_valid,
  input  logic             x,
  input  logic             cnt_clr,
  output logic             detector_out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
`ifdef PARAM_SEQ_DET_MEALY_EN
  output logic             armed,
  output logic             match_early
`else
  output logic             armed
`endif
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DETECT
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] count_d;
  logic             det_d;
  logic [PAT_W-1:0] window;
  logic             accept;
  logic             match;

  // Candidate window: the PAT_W-1 most recent bits followed by the incoming bit.
  assign window = {hist_q[PAT_W-2:0], x};
  assign accept = x_valid & ~pat_load & (state_q != S_IDLE);
  assign match  = accept & ((fill_q == FILL_LAST) | (state_q == S_DETECT))
                & (window == pattern_q);

  assign armed     = (state_q != S_IDLE);
  assign count_sat = &match_count;

`ifdef PARAM_SEQ_DET_MEALY_EN
  assign match_early = match;
`endif

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    det_d     = 1'b0;
    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = S_FILL;
    end else if (accept) begin
      det_d = match;
      if (match && !overlap_en) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = S_FILL;
      end else begin
        hist_d = window;
        if (state_q == S_FILL) begin
          fill_d = fill_q + FW'(1);
          if (fill_d == FILL_FULL) begin
            state_d = S_DETECT;
          end
        end
      end
    end
  end

  always_comb begin
    count_d = match_count;
    if (cnt_clr) begin
      count_d = match ? CNT_W'(1) : '0;
    end else if (match && !count_sat) begin
      count_d = match_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pattern_q    <= '0;
      hist_q       <= '0;
      fill_q       <= '0;
      detector_out <= 1'b0;
      match_count  <= '0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      detector_out <= det_d;
      match_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed bench for param_sequence_detector: a PAT_W=4/CNT_W=8 instance and a PAT_W=2/CNT_W=2 instance.
module tb_param_sequence_detector;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       pat_load0, overlap0, x_valid0, x0, cnt_clr0;
  logic [3:0] pat_in0;
  logic       det0, sat0, arm0;
  logic [7:0] cnt0;

  logic       pat_load1, overlap1, x_valid1, x1, cnt_clr1;
  logic [1:0] pat_in1;
  logic       det1, sat1, arm1;
  logic [1:0] cnt1;

`ifdef PARAM_SEQ_DET_MEALY_EN
  logic       early0, early1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_sequence_detector #(.PAT_W(4), .CNT_W(8)) u0 (
    .clk(clk), .reset_n(reset_n), .pat_load(pat_load0), .pat_in(pat_in0),
    .overlap_en(overlap0), .x_valid(x_valid0), .x(x0), .cnt_clr(cnt_clr0),
    .detector_out(det0), .match_count(cnt0), .count_sat(sat0),
`ifdef PARAM_SEQ_DET_MEALY_EN
    .armed(arm0), .match_early(early0)
`else
    .armed(arm0)
`endif
  );

  param_sequence_detector #(.PAT_W(2), .CNT_W(2)) u1 (
    .clk(clk), .reset_n(reset_n), .pat_load(pat_load1), .pat_in(pat_in1),
    .overlap_en(overlap1), .x_valid(x_valid1), .x(x1), .cnt_clr(cnt_clr1),
    .detector_out(det1), .match_count(cnt1), .count_sat(sat1),
`ifdef PARAM_SEQ_DET_MEALY_EN
    .armed(arm1), .match_early(early1)
`else
    .armed(arm1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step0(input logic v, input logic b, input logic ld, input logic clr);
    x_valid0  = v;
    x0        = b;
    pat_load0 = ld;
    cnt_clr0  = clr;
    @(posedge clk);
    #1;
    x_valid0  = 1'b0;
    pat_load0 = 1'b0;
    cnt_clr0  = 1'b0;
  endtask

  task automatic step1(input logic v, input logic b, input logic ld, input logic clr);
    x_valid1  = v;
    x1        = b;
    pat_load1 = ld;
    cnt_clr1  = clr;
    @(posedge clk);
    #1;
    x_valid1  = 1'b0;
    pat_load1 = 1'b0;
    cnt_clr1  = 1'b0;
  endtask

  logic [3:0] s4;
  logic [6:0] s7, exp_ov, exp_no;
  logic [2:0] s3;
  int         exp_c1 [6];
  int         exp_s1 [6];
  int         exp_d1 [6];

  initial begin
    reset_n   = 1'b0;
    pat_load0 = 1'b0; overlap0 = 1'b0; x_valid0 = 1'b0; x0 = 1'b0; cnt_clr0 = 1'b0; pat_in0 = 4'b1011;
    pat_load1 = 1'b0; overlap1 = 1'b1; x_valid1 = 1'b0; x1 = 1'b0; cnt_clr1 = 1'b0; pat_in1 = 2'b11;
    s4 = 4'b1011;
    s7 = 7'b1011011;
    exp_ov = 7'b0001001;
    exp_no = 7'b0001000;
    s3 = 3'b101;
    exp_c1 = '{0, 1, 2, 3, 3, 1};
    exp_s1 = '{0, 0, 0, 1, 1, 0};
    exp_d1 = '{0, 1, 1, 1, 1, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_det0", 32'(det0), 0);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_sat0", 32'(sat0), 0);
    chk("rst_arm0", 32'(arm0), 0);
    chk("rst_arm1", 32'(arm1), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    reset_n = 1'b1;

    // Not yet armed: the stream must be ignored.
    for (int i = 3; i >= 0; i--) begin
      step0(1'b1, s4[i], 1'b0, 1'b0);
      chk("unarmed_det", 32'(det0), 0);
    end
    chk("unarmed_arm", 32'(arm0), 0);
    chk("unarmed_cnt", 32'(cnt0), 0);

    // Load coincident with a valid bit: the bit is dropped.
    step0(1'b1, 1'b1, 1'b1, 1'b0);
    chk("load_arm", 32'(arm0), 1);
    chk("load_fill", 32'(u0.fill_q), 0);
    chk("load_det", 32'(det0), 0);

    overlap0 = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      step0(1'b1, s7[i], 1'b0, 1'b0);
      chk("ovl_det", 32'(det0), 32'(exp_ov[i]));
    end
    chk("ovl_cnt", 32'(cnt0), 2);

    step0(1'b0, 1'b0, 1'b1, 1'b0);
    overlap0 = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      step0(1'b1, s7[i], 1'b0, 1'b0);
      chk("novl_det", 32'(det0), 32'(exp_no[i]));
    end
    chk("novl_cnt", 32'(cnt0), 3);
    chk("novl_fill", 32'(u0.fill_q), 3);
    chk("novl_arm", 32'(arm0), 1);

    step0(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt", 32'(cnt0), 0);

    overlap0 = 1'b1;
    step0(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      step0(1'b1, s4[i], 1'b0, 1'b0);
      chk("gap_det_bit", 32'(det0), (i == 0) ? 1 : 0);
      for (int j = 0; j < 3; j++) begin
        step0(1'b0, 1'b1, 1'b0, 1'b0);
        chk("gap_det_idle", 32'(det0), 0);
      end
    end
    chk("gap_cnt", 32'(cnt0), 1);

    step0(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i >= 0; i--) begin
      step0(1'b1, s3[i], 1'b0, 1'b0);
    end
    reset_n = 1'b0;
    #1;
    chk("async_det", 32'(det0), 0);
    chk("async_cnt", 32'(cnt0), 0);
    chk("async_sat", 32'(sat0), 0);
    chk("async_arm", 32'(arm0), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step0(1'b1, 1'b1, 1'b0, 1'b0);
    chk("postrst_det", 32'(det0), 0);
    chk("postrst_arm", 32'(arm0), 0);
    for (int i = 2; i >= 0; i--) begin
      step0(1'b1, s3[i], 1'b0, 1'b0);
      chk("postrst_det_s", 32'(det0), 0);
    end
    chk("postrst_cnt", 32'(cnt0), 0);

    // Two-bit pattern with a two-bit saturating counter.
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    chk("u1_arm", 32'(arm1), 1);
    for (int i = 0; i < 6; i++) begin
      step1(1'b1, 1'b1, 1'b0, (i == 5));
      chk("u1_det", 32'(det1), 32'(exp_d1[i]));
      chk("u1_cnt", 32'(cnt1), 32'(exp_c1[i]));
      chk("u1_sat", 32'(sat1), 32'(exp_s1[i]));
    end
    step1(1'b0, 1'b0, 1'b0, 1'b0);
    chk("u1_det_idle", 32'(det1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
